// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encoding and default chain length for the stopwatch controller
package stopwatch_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} sw_state_t;
  localparam int DEF_NUM_DIGITS = 4;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk by TICK_DIV into a registered one-cycle tick, holding phase while paused
module tick_prescaler #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= run && cnt == LAST;
      if (run) cnt <= cnt == LAST ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/done sequencer driving the chained BCD digit enables, preset load and direction
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV   = 1_000_000,
  parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic                  mode_up,
  input  logic [NUM_DIGITS-1:0] thr,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  load,
  output logic                  up_dn,
  output logic                  running,
  output logic                  done
);
  sw_state_t state, nxt;
  logic arm, arm_nxt, tick, terminal, step, carry;
  assign terminal = &thr;
  assign step     = state == RUN && tick;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (state == RUN),
    .clr     (state == IDLE || state == LOAD || state == DONE),
    .tick    (tick)
  );
  always_comb begin
    nxt     = state;
    arm_nxt = arm;
    if (clear) begin
      nxt     = LOAD;
      arm_nxt = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start_stop) begin
          nxt     = LOAD;
          arm_nxt = 1'b1;
        end
        LOAD:    nxt = arm ? RUN : IDLE;
        RUN:     nxt = step && terminal ? DONE : start_stop ? PAUSE : RUN;
        PAUSE:   nxt = start_stop ? RUN : PAUSE;
        default: nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      arm     <= 1'b0;
      load    <= 1'b0;
      up_dn   <= 1'b1;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nxt;
      arm     <= arm_nxt;
      load    <= nxt == LOAD;
      running <= nxt == RUN;
      done    <= nxt == DONE;
      if (state == LOAD) up_dn <= mode_up;
    end
  end
  always_comb begin
    carry = step && !terminal;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_en[i] = carry;
      carry       = carry && thr[i];
    end
  end
endmodule
